// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU arbiter:
// opcodes, flag bit positions and the issue-register payload.
package alu_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int ALU_CTRL_WIDTH = 4;
  localparam int FLAG_WIDTH     = 4;
  localparam int NUM_REQ        = 2;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL  = 4'b0010;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT  = 4'b0011;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU = 4'b0100;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR  = 4'b0101;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA  = 4'b0111;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR   = 4'b1000;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND  = 4'b1001;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_LUI  = 4'b1011;

  // Flag bundle is {Zero, N, C, V}
  localparam int FLAG_ZERO = 3;
  localparam int FLAG_N    = 2;
  localparam int FLAG_C    = 1;
  localparam int FLAG_V    = 0;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     SrcA;
    logic [DATA_WIDTH-1:0]     SrcB;
    logic [ALU_CTRL_WIDTH-1:0] ALUControl;
    req_id_t                   Owner;
  } alu_issue_t;

  function automatic logic [FLAG_WIDTH-1:0] pack_flags(input logic zero,
                                                      input logic neg,
                                                      input logic carry,
                                                      input logic ovf);
    logic [FLAG_WIDTH-1:0] f;
    f            = '0;
    f[FLAG_ZERO] = zero;
    f[FLAG_N]    = neg;
    f[FLAG_C]    = carry;
    f[FLAG_V]    = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and external-ALU signals of the ALU arbiter.
// slave = arbiter side, master = requesters plus the ALU beside it.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic [NUM_REQ-1:0]                     ReqValid;
  logic [NUM_REQ-1:0]                     ReqReady;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     ReqSrcA;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     ReqSrcB;
  logic [NUM_REQ-1:0][ALU_CTRL_WIDTH-1:0] ReqALUControl;

  logic [DATA_WIDTH-1:0]                  AluSrcA;
  logic [DATA_WIDTH-1:0]                  AluSrcB;
  logic [ALU_CTRL_WIDTH-1:0]              AluControl;
  logic [DATA_WIDTH-1:0]                  AluResult;
  logic                                   AluZero;
  logic                                   AluN;
  logic                                   AluC;
  logic                                   AluV;

  logic [NUM_REQ-1:0]                     RspValid;
  logic [NUM_REQ-1:0]                     RspReady;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     RspResult;
  logic [NUM_REQ-1:0][FLAG_WIDTH-1:0]     RspFlags;

  modport slave (
    input  ReqValid, ReqSrcA, ReqSrcB, ReqALUControl, RspReady,
    input  AluResult, AluZero, AluN, AluC, AluV,
    output ReqReady, RspValid, RspResult, RspFlags,
    output AluSrcA, AluSrcB, AluControl
  );

  modport master (
    output ReqValid, ReqSrcA, ReqSrcB, ReqALUControl, RspReady,
    output AluResult, AluZero, AluN, AluC, AluV,
    input  ReqReady, RspValid, RspResult, RspFlags,
    input  AluSrcA, AluSrcB, AluControl
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// last_i is the id of the previous winner; it loses a tie.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external execute-stage ALU between two requesters: round-robin
// accept, one issue register feeding the ALU, one response slot per requester.
module alu_arbiter
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  alu_issue_t                         issue_q, issue_d;
  logic                               issue_valid_q, issue_valid_d;
  logic                               last_q, last_d;
  logic [NUM_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [NUM_REQ-1:0][FLAG_WIDTH-1:0] rsp_flags_q, rsp_flags_d;

  logic [NUM_REQ-1:0] owner_onehot;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] compete;
  logic [NUM_REQ-1:0] grant;
  logic               grant_sel;
  logic [FLAG_WIDTH-1:0] alu_flags;

  // A requester may only have one op in flight: it waits while its op sits
  // in the issue register, or while its slot is full and not being popped.
  always_comb begin
    owner_onehot = 2'b00;
    if (issue_valid_q) begin
      owner_onehot = (issue_q.Owner == REQ1) ? 2'b10 : 2'b01;
    end
    eligible = ~owner_onehot & (~rsp_valid_q | bus.RspReady);
    compete  = bus.ReqValid & eligible & {NUM_REQ{rst_n}};
  end

  rr_arb2 u_rr_arb2 (
    .req_i   (compete),
    .last_i  (last_q),
    .grant_o (grant)
  );

  assign grant_sel    = grant[1];
  assign bus.ReqReady = grant;

  always_comb begin
    issue_d       = '0;
    issue_valid_d = 1'b0;
    last_d        = last_q;
    if (|grant) begin
      issue_d.SrcA       = bus.ReqSrcA[grant_sel];
      issue_d.SrcB       = bus.ReqSrcB[grant_sel];
      issue_d.ALUControl = bus.ReqALUControl[grant_sel];
      issue_d.Owner      = grant_sel ? REQ1 : REQ0;
      issue_valid_d      = 1'b1;
      last_d             = grant_sel;
    end
  end

  assign alu_flags = pack_flags(bus.AluZero, bus.AluN, bus.AluC, bus.AluV);

  // An incoming write takes priority over a pop in the same cycle.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_onehot[i]) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_result_d[i] = bus.AluResult;
        rsp_flags_d[i]  = alu_flags;
      end else if (rsp_valid_q[i] && bus.RspReady[i]) begin
        rsp_valid_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
      last_q        <= 1'b1;
      rsp_valid_q   <= '0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
    end else begin
      issue_q       <= issue_d;
      issue_valid_q <= issue_valid_d;
      last_q        <= last_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
    end
  end

  assign bus.AluSrcA    = issue_q.SrcA;
  assign bus.AluSrcB    = issue_q.SrcB;
  assign bus.AluControl = issue_q.ALUControl;
  assign bus.RspValid   = rsp_valid_q;
  assign bus.RspResult  = rsp_result_q;
  assign bus.RspFlags   = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU beside the DUT and a
// transaction-level model (accept time + 2 = response time) of the arbiter.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_arbiter_if bus ();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] alu_ref(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] wide;
    logic [31:0] r;
    logic        c;
    logic        v;
    wide = '0;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    case (op)
      ALU_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[31:0];
        c    = wide[32];
        v    = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALU_SUB: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALU_SLL:  r = a << b[4:0];
      ALU_SLT:  r = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLTU: r = {31'b0, (a < b)};
      ALU_XOR:  r = a ^ b;
      ALU_SRL:  r = a >> b[4:0];
      ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:   r = a | b;
      ALU_AND:  r = a & b;
      ALU_LUI:  r = b;
      default:  r = '0;
    endcase
    return {(r == 32'd0), r[31], c, v, r};
  endfunction

  assign {bus.AluZero, bus.AluN, bus.AluC, bus.AluV, bus.AluResult} =
      alu_ref(bus.AluControl, bus.AluSrcA, bus.AluSrcB);

  // Transaction model: each requester holds at most one op, known by the
  // cycle its response becomes visible.
  bit          has_op [2];
  int          due    [2];
  logic [31:0] m_res  [2];
  logic [3:0]  m_flg  [2];
  int          m_last;
  int          cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      has_op[i] = 1'b0;
      due[i]    = 0;
    end
    m_last = 1;
  endtask

  function automatic logic [1:0] model_ready();
    logic [1:0] comp;
    for (int i = 0; i < 2; i++) begin
      bit in_issue;
      bit visible;
      in_issue = has_op[i] && (cyc == due[i] - 1);
      visible  = has_op[i] && (cyc >= due[i]);
      comp[i]  = bus.ReqValid[i] && !in_issue && (!visible || bus.RspReady[i]);
    end
    if (comp == 2'b11) return (m_last == 1) ? 2'b01 : 2'b10;
    return comp;
  endfunction

  task automatic tick();
    logic [1:0] er;
    logic [1:0] ev;
    bit         issue_busy;
    @(negedge clk);
    er = model_ready();
    chk("req_ready", bus.ReqReady, er);
    issue_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ev[i] = has_op[i] && (cyc >= due[i]);
      if (has_op[i] && (cyc == due[i] - 1)) issue_busy = 1'b1;
    end
    chk("rsp_valid", bus.RspValid, ev);
    for (int i = 0; i < 2; i++) begin
      if (ev[i]) begin
        chk($sformatf("rsp_result%0d", i), bus.RspResult[i], m_res[i]);
        chk($sformatf("rsp_flags%0d", i), bus.RspFlags[i], m_flg[i]);
      end
    end
    if (!issue_busy) chk("idle_alu_ctrl", {bus.AluControl, bus.AluSrcA}, 36'd0);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (ev[i] && bus.RspReady[i]) has_op[i] = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (er[i]) begin
        has_op[i] = 1'b1;
        due[i]    = cyc + 2;
        {m_flg[i], m_res[i]} = alu_ref(bus.ReqALUControl[i], bus.ReqSrcA[i], bus.ReqSrcB[i]);
        m_last = i;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    bus.ReqALUControl[i] = op;
    bus.ReqSrcA[i]       = a;
    bus.ReqSrcB[i]       = b;
    bus.ReqValid[i]      = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [3:0] ops [13];

  initial begin
    ops = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL,
            ALU_SRA, ALU_OR, ALU_AND, ALU_LUI, 4'b1010, 4'b1111};
    checks            = 0;
    failures          = 0;
    cyc               = 0;
    rst_n             = 1'b0;
    bus.ReqValid      = '0;
    bus.ReqSrcA       = '0;
    bus.ReqSrcB       = '0;
    bus.ReqALUControl = '0;
    bus.RspReady      = '0;
    model_reset();

    // Outputs under reset, with requests already asserted
    #2 bus.ReqValid = 2'b11;
    #1;
    chk("rst_req_ready", bus.ReqReady, 2'b00);
    chk("rst_rsp_valid", bus.RspValid, 2'b00);
    chk("rst_rsp_result", {bus.RspResult[1], bus.RspResult[0]}, 64'd0);
    chk("rst_rsp_flags", {bus.RspFlags[1], bus.RspFlags[0]}, 8'd0);
    chk("rst_alu_src", {bus.AluSrcA, bus.AluSrcB}, 64'd0);
    chk("rst_alu_ctrl", bus.AluControl, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.ReqValid = 2'b00;
    bus.RspReady = 2'b11;

    // Lone ADD on requester 0, two-cycle latency
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    #1 chk("add_ready", bus.ReqReady, 2'b01);
    tick();
    bus.ReqValid = 2'b00;
    tick();
    chk("add_valid", bus.RspValid, 2'b01);
    chk("add_result", bus.RspResult[0], 32'd12);
    chk("add_flags", bus.RspFlags[0], 4'b0000);
    tick();

    // Both requesters right after reset: req0 first, then alternate
    do_reset();
    set_req(0, ALU_SUB, 32'd3, 32'd5);
    set_req(1, ALU_ADD, 32'd100, 32'd23);
    #1 chk("tie_first", bus.ReqReady, 2'b01);
    tick();
    chk("tie_second", bus.ReqReady, 2'b10);
    tick();
    chk("sub_result", bus.RspResult[0], 32'hFFFF_FFFE);
    chk("sub_flags", bus.RspFlags[0], 4'b0110);
    chk("tie_third", bus.ReqReady, 2'b01);
    repeat (6) tick();

    // Backpressure on slot 0
    do_reset();
    bus.RspReady = 2'b10;
    set_req(0, ALU_ADD, 32'd5, 32'd7);
    set_req(1, ALU_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    repeat (8) tick();
    chk("bp_valid0", bus.RspValid[0], 1'b1);
    chk("bp_hold_result", bus.RspResult[0], 32'd12);
    chk("bp_blocked", bus.ReqReady[0], 1'b0);
    bus.RspReady = 2'b11;
    #1 chk("bp_pop_accept", bus.ReqReady, 2'b01);
    repeat (3) tick();

    // XOR to zero on requester 1
    do_reset();
    bus.ReqValid = 2'b00;
    set_req(1, ALU_XOR, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    tick();
    bus.ReqValid = 2'b00;
    tick();
    chk("xor_result", bus.RspResult[1], 32'd0);
    chk("xor_flags", bus.RspFlags[1], 4'b1000);
    tick();

    // Arithmetic shift right on requester 0
    set_req(0, ALU_SRA, 32'h8000_0000, 32'd4);
    tick();
    bus.ReqValid = 2'b00;
    tick();
    chk("sra_result", bus.RspResult[0], 32'hF800_0000);
    chk("sra_flags", bus.RspFlags[0], 4'b0100);
    tick();

    // Reset with issue stage and slot 1 both occupied
    bus.RspReady = 2'b00;
    set_req(1, ALU_ADD, 32'd1, 32'd2);
    tick();
    bus.ReqValid = 2'b00;
    set_req(0, ALU_ADD, 32'd9, 32'd9);
    tick();
    chk("pre_rst_valid", bus.RspValid, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.RspValid, 2'b00);
    chk("mid_rst_ready", bus.ReqReady, 2'b00);
    chk("mid_rst_ctrl", {bus.AluControl, bus.AluSrcA}, 36'd0);
    chk("mid_rst_result", bus.RspResult[1], 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.RspReady = 2'b11;
    set_req(0, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    set_req(1, ALU_AND, 32'hFFFF_0000, 32'h00FF_FF00);
    #1 chk("post_rst_tie", bus.ReqReady, 2'b01);
    tick();
    bus.ReqValid = 2'b00;
    tick();
    chk("post_rst_valid", bus.RspValid, 2'b01);
    chk("post_rst_result", bus.RspResult[0], 32'h0000_00FF);
    tick();

    // Randomised traffic against the transaction model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        bus.ReqValid[i]      = ($urandom_range(0, 3) != 0);
        bus.ReqALUControl[i] = ops[$urandom_range(0, 12)];
        bus.ReqSrcA[i]       = $urandom();
        bus.ReqSrcB[i]       = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 40));
        bus.RspReady[i]      = ($urandom_range(0, 2) != 0);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single execute-stage ALU between two requesters, requester 0 and requester 1 (e.g. the integer pipe and a multi-cycle/CSR helper), using valid/ready handshakes and two-way round-robin arbitration. Accepted operations are registered into one issue stage that drives the combinational ALU. Each result and its flags are captured into a per-requester response slot. The ALU instance itself sits beside this block at top level and is wired to its Alu* ports.

## Interface
- DATA_WIDTH, 32, operand/result width
- ALU_CTRL_WIDTH, 4, ALU operation code width
- FLAG_WIDTH, 4, flag bundle {Zero, N, C, V}, bit 3 = Zero
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- ReqValid  input  2  per-requester operation valid
- ReqReady  output  2  per-requester accept (combinational)
- ReqSrcA / ReqSrcB  input  2×DATA_WIDTH  per-requester operands
- ReqALUControl  input  2×ALU_CTRL_WIDTH  per-requester opcode
- AluSrcA / AluSrcB  output  DATA_WIDTH  to ALU, from issue register
- AluControl  output  ALU_CTRL_WIDTH  to ALU, from issue register
- AluResult  input  DATA_WIDTH  from ALU
- AluZero / AluN / AluC / AluV  input  1  ALU flags
- RspValid  output  2  response slot full
- RspReady  input  2  requester consumes response
- RspResult  output  2×DATA_WIDTH  captured result
- RspFlags  output  2×FLAG_WIDTH  captured {Zero,N,C,V}

## Operation
- Each requester has at most one outstanding op, either in the issue stage or in its response slot.
- Eligible[i] = !(IssueValid && IssueOwner==i) && (!RspValid[i] || RspReady[i]).
- Only eligible and valid requesters compete.
  - One competitor: it wins.
  - Two competitors: the one not in LastGrant wins.
- ReqReady[i] = win[i]; at most one bit is set. Forced 0 while rst_n is low.
- LastGrant updates on every grant. Reset value 1, so requester 0 wins the first tie.
- Grant: SrcA, SrcB, ALUControl and the owner id load into the issue register; IssueValid is set.
- No grant: IssueValid clears. Issue operands and control load zeros, so AluControl is 4'b0000.
- IssueValid: AluResult and the four flags are written into slot IssueOwner; RspValid[IssueOwner] is set.
- RspValid[i] && RspReady[i] with no incoming write: RspValid[i] clears. Pop and write in the same cycle is legal; the write wins and RspValid stays 1.
- Opcodes pass through unchanged and are not checked. Undefined codes return what the ALU returns: zero result, Zero=1.
- Asynchronous reset clears IssueValid, the issue operands, RspValid, RspResult and RspFlags, and sets LastGrant=1. In-flight ops are discarded without a response.

## Timing
- Accept edge t → issue register valid during cycle t+1 → RspValid high from cycle t+2.
- Fixed latency: 2 cycles.
- ALU path: issue register → external ALU → response slot, one cycle. The ALU's combinational depth must close in that single cycle.
- Aggregate throughput: 1 op/cycle when both requesters alternate.
- Single-requester throughput: 1 op per 2 cycles. A pop at t+2 allows a new accept in the same cycle.
- RspResult/RspFlags hold stable while RspValid=1 and RspReady=0.
- Outputs in reset: ReqReady=0, RspValid=0, RspResult=0, RspFlags=0, AluSrcA/B=0, AluControl=0.

## Structure
- Shared package alu_pkg holds:
  - ALU opcode constants: ALU_ADD 0000, ALU_SUB 0001, ALU_SLL 0010, ALU_SLT 0011, ALU_SLTU 0100, ALU_XOR 0101, ALU_SRL 0110, ALU_SRA 0111, ALU_OR 1000, ALU_AND 1001, ALU_LUI 1011.
  - Flag bit indices.
  - The alu_issue_t struct {SrcA, SrcB, ALUControl, Owner}.
- Sub-module rr_arb2: two-way round-robin picker with inputs req[1:0], last, and output grant[1:0]. Combinational only; the LastGrant register stays in the parent.

## Test plan
- Req0 ADD 5+7 alone at t: ReqReady0=1 at t; RspValid0=1 at t+2; RspResult0=12; RspFlags0=0000.
- Both requesters valid right after reset:
  - Req0 SUB 3−5 is granted first: RspResult0=0xFFFFFFFE, N=1, C=1.
  - Req1 is granted at t+1.
  - Grants continue alternating; the issue stage is valid every cycle.
- Backpressure:
  - Hold RspReady0=0 after one req0 result: ReqReady0 stays 0 and RspResult0 stays stable; req1 is served every 2 cycles.
  - Raise RspReady0: the pop and ReqReady0=1 occur in the same cycle.
- Req1 XOR 0xA5A5A5A5^0xA5A5A5A5 → RspResult1=0, Zero=1.
- Req0 SRA 0x80000000 by 4 (ALUControl 0111) → RspResult0=0xF8000000, N=1.
- Reset mid-operation:
  - With the issue stage and slot 1 both occupied, pull rst_n low mid-cycle: RspValid drops immediately, no clock edge needed.
  - After release, the first tie is granted to req0 and its response carries only fresh data.
